note_sequencer: RTL and testbench

Parametrised record/playback sequencer for guitar note vectors. It captures one note word per beat into an internal memory and replays the stored sequence at the same tempo, either once or looped. It sits between the string/fret coordinate conversion logic and the audio/display consumers. It replaces the fixed 64x32 record/play datapath and its separate clock divider.

---
 rtl/note_seq_pkg.sv | 20 ++
 rtl/note_sequencer_beat_timer.sv | 48 ++++
 rtl/note_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_note_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// note_seq_pkg
//   Shared definitions for the note sequencer slice: the sequencer state
//   encoding (visible on the state output port) and the default parameter
//   values used by note_sequencer.
//   Optional feature macro used elsewhere in the slice: NOTE_SEQ_LOOP_EN.
package note_seq_pkg;

  // Sequencer state; the encoding appears directly on the state port.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REC  = 2'b01,
    PLAY = 2'b10
  } seq_state_t;

  // Default parameter values.
  localparam int NOTE_W_DEF = 32;
  localparam int DEPTH_DEF  = 64;
  localparam int TICK_W_DEF = 27;

endpackage

// File: rtl/note_sequencer_beat_timer.sv
// beat_timer
//   Reloadable down-counter that produces the beat pulse for the sequencer.
//   The period is latched on load, so later changes of period are ignored
//   until the next load. A period of 0 is treated as 1 (beat every cycle).
// Ports:
//   clk     in   system clock
//   resetn  in   asynchronous active-low reset
//   load    in   latch period and restart the count (issued on leaving IDLE)
//   en      in   count enable (high while recording or playing)
//   period  in   beat period in clk cycles
//   beat    out  high during the last cycle of each beat period while en
module beat_timer #(
  parameter int TICK_W = 27
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              en,
  input  logic [TICK_W-1:0] period,
  output logic              beat
);

  logic [TICK_W-1:0] reload_val;
  logic [TICK_W-1:0] reload_reg;
  logic [TICK_W-1:0] cnt_reg;

  // max(period,1)-1
  assign reload_val = (period == '0) ? '0 : period - TICK_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reload_reg <= '0;
      cnt_reg    <= '0;
    end else if (load) begin
      reload_reg <= reload_val;
      cnt_reg    <= reload_val;
    end else if (en) begin
      if (cnt_reg == '0) begin
        cnt_reg <= reload_reg;
      end else begin
        cnt_reg <= cnt_reg - TICK_W'(1);
      end
    end
  end

  assign beat = en && (cnt_reg == '0);

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
//   Record/playback sequencer for guitar note vectors. In REC it ORs the live
//   note vector over each beat and stores one word per beat; in PLAY it
//   replays the stored words at the beat rate, once or looped.
//   Optional feature: define NOTE_SEQ_LOOP_EN to honour the loop input;
//   otherwise playback is always one-shot and loop is ignored.
// Ports:
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset
//   tick_max    in   beat period in clk cycles, sampled on leaving IDLE
//   rec_start   in   pulse: start recording from address 0
//   play_start  in   pulse: start playback from address 0
//   stop        in   pulse: abort REC/PLAY
//   loop        in   level: wrap playback at end of sequence
//   note_in     in   live note vector
//   beat        out  pulse at each beat boundary in REC/PLAY
//   note_out    out  last played note word
//   note_valid  out  pulse when note_out updates
//   state       out  00 IDLE, 01 REC, 10 PLAY
//   length      out  number of stored beats
//   full        out  length == DEPTH
//   done        out  pulse the cycle after any REC/PLAY termination
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int TICK_W = TICK_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [TICK_W-1:0] tick_max,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              loop,
  input  logic [NOTE_W-1:0] note_in,
  output logic              beat,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   length,
  output logic              full,
  output logic              done
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] LAST_LEN = LEN_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

  seq_state_t state_reg, state_next;

  logic [LEN_W-1:0]  length_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [NOTE_W-1:0] acc_reg, acc_next;
  logic [NOTE_W-1:0] note_out_reg;
  logic              note_valid_reg;
  logic              done_reg, done_next;

  logic timer_load;
  logic timer_en;
  logic wr_en;
  logic rd_en;
  logic rec_clear;
  logic rd_restart;
  logic rd_last;
  logic loop_en;

  logic [NOTE_W-1:0] mem [DEPTH];

`ifdef NOTE_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en     = 1'b0;
`endif

  assign timer_en = (state_reg != IDLE);

  beat_timer #(
    .TICK_W (TICK_W)
  ) u_beat_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (timer_load),
    .en     (timer_en),
    .period (tick_max),
    .beat   (beat)
  );

  // Current read address is the last stored beat.
  assign rd_last = ({1'b0, rd_ptr_reg} == (length_reg - LEN_W'(1)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode. stop wins over any beat in the same
  // cycle, so a beat coinciding with stop neither writes nor reads.
  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rec_clear  = 1'b0;
    rd_restart = 1'b0;
    done_next  = 1'b0;
    acc_next   = '0;
    case (state_reg)
      IDLE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (rec_start) begin
          state_next = REC;
          timer_load = 1'b1;
          rec_clear  = 1'b1;
        end else if (play_start) begin
          if (length_reg != '0) begin
            state_next = PLAY;
            timer_load = 1'b1;
            rd_restart = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      REC: begin
        if (stop) begin
          // partial beat in acc_reg is dropped (acc_next stays 0)
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (beat) begin
          wr_en = 1'b1;
          if (length_reg == LAST_LEN) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          acc_next = acc_reg | note_in;
        end
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (beat) begin
          rd_en = 1'b1;
          if (rd_last && !loop_en) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      length_reg     <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      acc_reg        <= '0;
      note_out_reg   <= '0;
      note_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg       <= done_next;
      note_valid_reg <= rd_en;
      acc_reg        <= acc_next;

      if (rec_clear) begin
        length_reg <= '0;
        wr_ptr_reg <= '0;
      end else if (wr_en) begin
        length_reg <= length_reg + LEN_W'(1);
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end

      if (rd_restart) begin
        rd_ptr_reg <= '0;
      end else if (rd_en) begin
        rd_ptr_reg <= rd_last ? '0 : rd_ptr_reg + ADDR_W'(1);
      end

      // Synchronous read straight into the output register; it holds
      // until the next playback beat.
      if (rd_en) begin
        note_out_reg <= mem[rd_ptr_reg];
      end
    end
  end

  // The beat-cycle note_in is folded in so a strike on the last cycle of a
  // beat is not lost.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= acc_reg | note_in;
    end
  end

  assign state      = state_reg;
  assign length     = length_reg;
  assign full       = (length_reg == FULL_LEN);
  assign note_out   = note_out_reg;
  assign note_valid = note_valid_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
//   Scoreboard bench for note_sequencer (NOTE_W=8, DEPTH=4, TICK_W=8).
//   Expected note words are pushed when recording stimulus is driven and
//   popped whenever the DUT raises note_valid.
module tb_note_sequencer;

  localparam int NW = 8;
  localparam int DP = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [TW-1:0] tick_max;
  logic          rec_start;
  logic          play_start;
  logic          stop;
  logic          loop;
  logic [NW-1:0] note_in;
  logic          beat;
  logic [NW-1:0] note_out;
  logic          note_valid;
  logic [1:0]    state;
  logic [2:0]    length;
  logic          full;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] rec_mem [DP];
  logic [NW-1:0] acc;
  logic [NW-1:0] pat [3][4];

  always #5 clk = ~clk;

  note_sequencer #(
    .NOTE_W (NW),
    .DEPTH  (DP),
    .TICK_W (TW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tick_max   (tick_max),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .loop       (loop),
    .note_in    (note_in),
    .beat       (beat),
    .note_out   (note_out),
    .note_valid (note_valid),
    .state      (state),
    .length     (length),
    .full       (full),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are inspected 1 ns after the edge. Any
  // note_valid is matched against the scoreboard and must follow a beat.
  task automatic step();
    logic          b;
    logic [NW-1:0] e;
    b = beat;
    @(posedge clk);
    #1;
    if (note_valid) begin
      check("nv_after_beat", 32'(b), 32'd1);
      check("nv_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("note_out", 32'(note_out), 32'(e));
        $display("note_valid note_out=0x%02h expected=0x%02h", note_out, e);
      end
    end
  endtask

  task automatic pulse_start(input logic r, input logic p);
    rec_start  = r;
    play_start = p;
    step();
    rec_start  = 1'b0;
    play_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic drain_q(input int budget, input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    pat[0] = '{8'h01, 8'h01, 8'h40, 8'h40};
    pat[1] = '{8'h02, 8'h00, 8'h00, 8'h80};
    pat[2] = '{8'h00, 8'h10, 8'h10, 8'h00};

    resetn = 1'b0; tick_max = 4; rec_start = 0; play_start = 0;
    stop = 0; loop = 0; note_in = '0;
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    check("rst_note_out", 32'(note_out), 32'd0);
    check("rst_note_valid", 32'(note_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_beat", 32'(beat), 32'd0);
    resetn = 1'b1;
    step();

    // play with nothing recorded
    pulse_start(1'b0, 1'b1);
    $display("empty play: state=%0d done=%0b", state, done);
    check("empty_state", 32'(state), 32'd0);
    check("empty_done", 32'(done), 32'd1);
    step();
    check("empty_done_clr", 32'(done), 32'd0);

    // record 3 beats at period 4, then stop mid-beat
    tick_max = 4;
    pulse_start(1'b1, 1'b0);
    check("rec_state", 32'(state), 32'd1);
    tick_max = 9;  // must be ignored until the next start
    for (int b = 0; b < 3; b++) begin
      acc = '0;
      for (int c = 0; c < 4; c++) begin
        note_in = pat[b][c];
        acc = acc | note_in;
        check("rec_beat", 32'(beat), 32'(c == 3));
        step();
      end
      rec_mem[b] = acc;
      $display("rec beat %0d word=0x%02h length=%0d", b, acc, length);
    end
    check("rec_len3", 32'(length), 32'd3);
    note_in = 8'hff;
    step(); step();
    pulse_stop();
    note_in = '0;
    check("rec_stop_state", 32'(state), 32'd0);
    check("rec_stop_done", 32'(done), 32'd1);
    check("rec_stop_len", 32'(length), 32'd3);
    step();
    check("rec_stop_done_clr", 32'(done), 32'd0);

    // one-shot playback
    loop = 1'b0; tick_max = 2;
    for (int i = 0; i < 3; i++) exp_q.push_back(rec_mem[i]);
    pulse_start(1'b0, 1'b1);
    check("play_state", 32'(state), 32'd2);
    wait_done(40, "play_done");
    check("play_done_with_last", 32'(note_valid), 32'd1);
    check("play_end_state", 32'(state), 32'd0);
    check("play_q_empty", 32'(exp_q.size()), 32'd0);
    check("play_len_kept", 32'(length), 32'd3);

    // loop input
    loop = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(rec_mem[i % 3]);
    pulse_start(1'b0, 1'b1);
    drain_q(60, "loop_drain");
    pulse_stop();
    check("loop_stop_done", 32'(done), 32'd1);
    check("loop_stop_state", 32'(state), 32'd0);
    check("loop_hold", 32'(note_out), 32'(rec_mem[1]));
`else
    for (int i = 0; i < 3; i++) exp_q.push_back(rec_mem[i]);
    pulse_start(1'b0, 1'b1);
    wait_done(40, "noloop_done");
    check("noloop_state", 32'(state), 32'd0);
    check("noloop_q_empty", 32'(exp_q.size()), 32'd0);
`endif
    loop = 1'b0;

    // stop during playback: note_out holds, no further notes
    tick_max = 3;
    exp_q.push_back(rec_mem[0]);
    exp_q.push_back(rec_mem[1]);
    pulse_start(1'b0, 1'b1);
    drain_q(40, "pstop_drain");
    pulse_stop();
    check("pstop_done", 32'(done), 32'd1);
    check("pstop_state", 32'(state), 32'd0);
    step(); step(); step();
    check("pstop_hold", 32'(note_out), 32'(rec_mem[1]));

    // asynchronous reset during playback
    exp_q.push_back(rec_mem[0]);
    pulse_start(1'b0, 1'b1);
    drain_q(40, "rst_play_drain");
    #2;
    resetn = 1'b0;
    #1;
    $display("reset mid-play: state=%0d length=%0d note_out=0x%02h", state, length, note_out);
    check("arst_state", 32'(state), 32'd0);
    check("arst_length", 32'(length), 32'd0);
    check("arst_note_out", 32'(note_out), 32'd0);
    check("arst_note_valid", 32'(note_valid), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    step(); step();
    resetn = 1'b1;
    step();

    // fill memory: auto-stop at DEPTH beats
    tick_max = 2;
    pulse_start(1'b1, 1'b0);
    for (int b = 0; b < DP; b++) begin
      acc = '0;
      for (int c = 0; c < 2; c++) begin
        note_in = NW'($urandom);
        acc = acc | note_in;
        step();
      end
      rec_mem[b] = acc;
      $display("rec beat %0d word=0x%02h length=%0d", b, acc, length);
    end
    note_in = '0;
    check("full_state", 32'(state), 32'd0);
    check("full_done", 32'(done), 32'd1);
    check("full_flag", 32'(full), 32'd1);
    check("full_len", 32'(length), 32'd4);

    // playback at minimum period: one note per cycle
    tick_max = 0;
    for (int i = 0; i < DP; i++) exp_q.push_back(rec_mem[i]);
    pulse_start(1'b0, 1'b1);
    n = 0;
    while (!done && n < 20) begin
      check("fast_beat", 32'(beat), 32'd1);
      step();
      n++;
    end
    check("fast_done", 32'(done), 32'd1);
    check("fast_cycles", 32'(n), 32'(DP));
    check("fast_q_empty", 32'(exp_q.size()), 32'd0);

    // simultaneous starts: record wins
    pulse_start(1'b1, 1'b1);
    check("both_state", 32'(state), 32'd1);
    check("both_len", 32'(length), 32'd0);
    pulse_stop();
    check("both_stop_done", 32'(done), 32'd1);
    check("both_stop_state", 32'(state), 32'd0);
    check("both_full_clr", 32'(full), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
